io_input_capture: RTL and testbench
===================================

IO_INPUT_CAPTURE -- requirements
Module: io_input_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable cycles before an input is accepted (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports BTNL, BTNR  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-005 SHALL have port SW  input  16  raw asynchronous slide switches.
REQ-006 SHALL have port addr  input  8  CPU byte address, low 8 bits of the data address.
REQ-007 SHALL have port wr_en  input  1  CPU store strobe for this block.
REQ-008 SHALL have port wdata  input  32  CPU store data.
REQ-009 SHALL have port rdata  output  32  CPU load data, combinational.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL pass every raw input (BTNL, BTNR, each SW bit) through a 2-flop synchronizer, giving the synchronized value s.
REQ-012 SHALL hold s_q, which is s delayed one cycle, for each channel.
REQ-013 SHALL run three debounce channels: L, R, and SW (16-bit word as one channel); each channel has a debounced value db and a 16-bit counter cnt.
REQ-014 Per edge, per channel: if s==db or s!=s_q, cnt<=0; else if cnt==DEBOUNCE_CYCLES-1, db<=s and cnt<=0; else cnt<=cnt+1.
REQ-015 Latency: a raw change first captured at edge k SHALL appear in db after edge k+2+DEBOUNCE_CYCLES. This is 7 edges for the default.
REQ-016 A bounce that returns s to db, or changes s before acceptance, SHALL restart the counter, and db SHALL stay unchanged.
REQ-017 A 0->1 update of db_L or db_R SHALL set pending bit PL or PR on the same edge. 1->0 updates SHALL set nothing.
REQ-018 Any update of db_SW SHALL set pending bit PS on the same edge.
REQ-019 Register map, addr[7:2] decoded, addr[1:0] ignored:
  0x00 STATUS (read): {29'b0, PS, PR, PL}. A write clears the bits where wdata is 1 (write-1-to-clear).
  0x04 SWITCH (read-only): {16'b0, db_SW}.
  0x08 BUTTON (read-only): {30'b0, db_R, db_L}.
  0x0C IRQ_EN (read/write): {29'b0, en[2:0]}.
  All other addresses read 0 and ignore writes.
REQ-020 A write-1-to-clear and a set of the same pending bit on the same edge SHALL leave the bit set.
REQ-021 Writes to read-only registers SHALL have no effect.
REQ-022 irq SHALL equal |({PS,PR,PL} & en), registered with a 1-cycle lag behind the pending/enable state.
REQ-023 rdata SHALL reflect register state after the most recent edge, with 0 added cycles of latency.

Reset
REQ-024 While reset==0 at an edge, all of the following SHALL be cleared to 0: synchronizers, s_q, cnt, db_L, db_R, db_SW, PL, PR, PS, en, and irq.
REQ-025 Reset SHALL override any concurrent CPU write.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count.
REQ-027 After reset release, an SW value held nonzero SHALL be accepted per REQ-015 and SHALL set PS.

Verification
REQ-028 Reset: SW=16'h1234 held, reset low 2 cycles, then high. Required: SWITCH reads 0 until the 7th edge after release, then 0x1234, and STATUS==0x4.
REQ-029 Debounce: BTNR pulses high 2 cycles, low 1 cycle, then high steadily. Required: PR stays 0 during the bounces, and PR==1 exactly 7 edges after the final rising edge was captured.
REQ-030 Clear race: PL pending, then BTNL released and pressed again so its acceptance edge coincides with a store of 0x1 to 0x00. Required: PL remains 1. A later store of 0x1 with no press leaves PL==0.
REQ-031 Interrupt: store 0x2 to IRQ_EN, then press BTNR. Required: irq rises 1 edge after PR sets. Storing 0x2 to STATUS drops irq 1 edge later. Pressing BTNL with en=0x2 never raises irq.
REQ-032 Decode: store 0xFFFF to 0x04, 0x08 and 0x10. Required: SWITCH and BUTTON are unchanged, and reads of 0x10 and 0xFC return 0.
REQ-033 Mid-operation reset: BTNL goes high, and reset is pulsed low for 1 cycle at debounce count 2. Required: PL stays 0 until 7 edges after release, then becomes 1.

Source files
------------

// File: rtl/io_input_capture.sv
// Input capture block: synchronizes and debounces two pushbuttons and a 16-bit switch bank,
// latches press/change events as pending bits and exposes them through a small CPU register map.
module io_input_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic [15:0] SW,
    input  logic [7:0]  addr,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [15:0] CNT_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]  REG_STATUS = 6'h00;
    localparam logic [5:0]  REG_SWITCH = 6'h01;
    localparam logic [5:0]  REG_BUTTON = 6'h02;
    localparam logic [5:0]  REG_IRQ_EN = 6'h03;

    // Raw inputs packed as {SW, BTNR, BTNL} through the synchronizer and delay stages
    logic [17:0] sync1_q;
    logic [17:0] sync2_q;
    logic [17:0] s_dly_q;

    logic        s_l;
    logic        s_r;
    logic [15:0] s_sw;
    logic        sd_l;
    logic        sd_r;
    logic [15:0] sd_sw;

    logic [15:0] cnt_l_q;
    logic [15:0] cnt_l_d;
    logic [15:0] cnt_r_q;
    logic [15:0] cnt_r_d;
    logic [15:0] cnt_sw_q;
    logic [15:0] cnt_sw_d;

    logic        db_l_q;
    logic        db_l_d;
    logic        db_r_q;
    logic        db_r_d;
    logic [15:0] db_sw_q;
    logic [15:0] db_sw_d;

    logic [2:0]  pend_q;
    logic [2:0]  pend_d;
    logic [2:0]  en_q;
    logic [2:0]  en_d;
    logic [2:0]  pend_set;
    logic [2:0]  pend_clr;
    logic        irq_q;
    logic        irq_d;

    logic [5:0]  word;
    logic        unused_bits;

    assign s_l   = sync2_q[0];
    assign s_r   = sync2_q[1];
    assign s_sw  = sync2_q[17:2];
    assign sd_l  = s_dly_q[0];
    assign sd_r  = s_dly_q[1];
    assign sd_sw = s_dly_q[17:2];

    assign word        = addr[7:2];
    assign unused_bits = ^{addr[1:0], wdata[31:3]};

    // Debounce: any instability or return to the accepted value restarts the count
    always_comb begin
        cnt_l_d = cnt_l_q;
        db_l_d  = db_l_q;
        if ((s_l == db_l_q) || (s_l != sd_l)) begin
            cnt_l_d = '0;
        end else if (cnt_l_q == CNT_LAST) begin
            db_l_d  = s_l;
            cnt_l_d = '0;
        end else begin
            cnt_l_d = cnt_l_q + 16'd1;
        end
    end

    always_comb begin
        cnt_r_d = cnt_r_q;
        db_r_d  = db_r_q;
        if ((s_r == db_r_q) || (s_r != sd_r)) begin
            cnt_r_d = '0;
        end else if (cnt_r_q == CNT_LAST) begin
            db_r_d  = s_r;
            cnt_r_d = '0;
        end else begin
            cnt_r_d = cnt_r_q + 16'd1;
        end
    end

    always_comb begin
        cnt_sw_d = cnt_sw_q;
        db_sw_d  = db_sw_q;
        if ((s_sw == db_sw_q) || (s_sw != sd_sw)) begin
            cnt_sw_d = '0;
        end else if (cnt_sw_q == CNT_LAST) begin
            db_sw_d  = s_sw;
            cnt_sw_d = '0;
        end else begin
            cnt_sw_d = cnt_sw_q + 16'd1;
        end
    end

    // Set wins over a concurrent write-1-to-clear of the same bit
    always_comb begin
        pend_set = {(db_sw_d != db_sw_q), (~db_r_q & db_r_d), (~db_l_q & db_l_d)};
        pend_clr = (wr_en && (word == REG_STATUS)) ? wdata[2:0] : 3'b000;
        pend_d   = (pend_q & ~pend_clr) | pend_set;
        en_d     = (wr_en && (word == REG_IRQ_EN)) ? wdata[2:0] : en_q;
        irq_d    = |(pend_q & en_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            s_dly_q  <= '0;
            cnt_l_q  <= '0;
            cnt_r_q  <= '0;
            cnt_sw_q <= '0;
            db_l_q   <= 1'b0;
            db_r_q   <= 1'b0;
            db_sw_q  <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= {SW, BTNR, BTNL};
            sync2_q  <= sync1_q;
            s_dly_q  <= sync2_q;
            cnt_l_q  <= cnt_l_d;
            cnt_r_q  <= cnt_r_d;
            cnt_sw_q <= cnt_sw_d;
            db_l_q   <= db_l_d;
            db_r_q   <= db_r_d;
            db_sw_q  <= db_sw_d;
            pend_q   <= pend_d;
            en_q     <= en_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (word)
            REG_STATUS: rdata = {29'b0, pend_q};
            REG_SWITCH: rdata = {16'b0, db_sw_q};
            REG_BUTTON: rdata = {30'b0, db_r_q, db_l_q};
            REG_IRQ_EN: rdata = {29'b0, en_q};
            default:    rdata = 32'h0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_io_input_capture.sv
// Directed bench for io_input_capture: register-map vector table plus hand-written
// debounce, clear-race, interrupt and reset sequences.
module tb_io_input_capture;

    logic        clk;
    logic        reset;
    logic        BTNL;
    logic        BTNR;
    logic [15:0] SW;
    logic [7:0]  addr;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_pass;
    int n_total;

    typedef struct {
        bit          do_wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [0:15];

    io_input_capture #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .BTNL  (BTNL),
        .BTNR  (BTNR),
        .SW    (SW),
        .addr  (addr),
        .wr_en (wr_en),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string nm);
        addr = a;
        #1;
        check(nm, rdata, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        step(1);
        wr_en = 1'b0;
        wdata = 32'h0;
    endtask

    initial begin
        logic [2:0] bounce;
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{1'b0, 8'h04, 32'h0,        32'h0000_1234, "switch_rd"};
        vecs[1]  = '{1'b0, 8'h05, 32'h0,        32'h0000_1234, "switch_rd_lowbits"};
        vecs[2]  = '{1'b0, 8'h08, 32'h0,        32'h0000_0000, "button_rd"};
        vecs[3]  = '{1'b1, 8'h04, 32'h0000_FFFF, 32'h0,        "wr_switch"};
        vecs[4]  = '{1'b0, 8'h04, 32'h0,        32'h0000_1234, "switch_ro"};
        vecs[5]  = '{1'b1, 8'h08, 32'h0000_FFFF, 32'h0,        "wr_button"};
        vecs[6]  = '{1'b0, 8'h08, 32'h0,        32'h0000_0000, "button_ro"};
        vecs[7]  = '{1'b1, 8'h10, 32'h0000_FFFF, 32'h0,        "wr_0x10"};
        vecs[8]  = '{1'b0, 8'h10, 32'h0,        32'h0000_0000, "rd_0x10"};
        vecs[9]  = '{1'b0, 8'hFC, 32'h0,        32'h0000_0000, "rd_0xFC"};
        vecs[10] = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0,        "wr_irq_en"};
        vecs[11] = '{1'b0, 8'h0C, 32'h0,        32'h0000_0007, "irq_en_rd"};
        vecs[12] = '{1'b0, 8'h0F, 32'h0,        32'h0000_0007, "irq_en_rd_lowbits"};
        vecs[13] = '{1'b1, 8'h0C, 32'h0,        32'h0,        "wr_irq_en_zero"};
        vecs[14] = '{1'b0, 8'h0C, 32'h0,        32'h0000_0000, "irq_en_cleared"};
        vecs[15] = '{1'b0, 8'h00, 32'h0,        32'h0000_0000, "status_idle"};

        // Reset held with a concurrent IRQ_EN write and SW=0x1234
        reset = 1'b0;
        BTNL  = 1'b0;
        BTNR  = 1'b0;
        SW    = 16'h1234;
        addr  = 8'h0C;
        wdata = 32'h7;
        wr_en = 1'b1;
        step(2);
        wr_en = 1'b0;
        wdata = 32'h0;
        rd_chk(8'h04, 32'h0, "rst_switch");
        rd_chk(8'h00, 32'h0, "rst_status");
        rd_chk(8'h0C, 32'h0, "rst_irq_en");
        check("rst_irq", {31'b0, irq}, 32'h0);

        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            rd_chk(8'h04, (i == 7) ? 32'h1234 : 32'h0, $sformatf("rel_switch_e%0d", i));
        end
        rd_chk(8'h00, 32'h4, "rel_status_ps");
        rd_chk(8'h0C, 32'h0, "rel_irq_en_write_blocked");
        wr(8'h00, 32'h4);
        rd_chk(8'h00, 32'h0, "ps_w1c");

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].a, vecs[i].d);
            else rd_chk(vecs[i].a, vecs[i].exp, vecs[i].name);
        end

        // BTNR bounce: high 2, low 1, then steady high
        bounce = 3'b011;
        for (int i = 0; i < 3; i++) begin
            BTNR = bounce[i];
            step(1);
            addr = 8'h00;
            #1;
            check($sformatf("bounce_pr_%0d", i), {31'b0, rdata[1]}, 32'h0);
        end
        BTNR = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            addr = 8'h00;
            #1;
            check($sformatf("pr_after_e%0d", i), {31'b0, rdata[1]}, (i == 7) ? 32'd1 : 32'd0);
        end
        rd_chk(8'h08, 32'h2, "button_r");
        check("irq_disabled", {31'b0, irq}, 32'h0);
        wr(8'h00, 32'h2);

        // Interrupt path
        BTNR = 1'b0;
        step(8);
        rd_chk(8'h00, 32'h0, "release_no_set");
        rd_chk(8'h08, 32'h0, "button_released");
        wr(8'h0C, 32'h2);
        rd_chk(8'h0C, 32'h2, "irq_en_2");
        BTNR = 1'b1;
        step(7);
        rd_chk(8'h00, 32'h2, "pr_set_int");
        check("irq_lag", {31'b0, irq}, 32'h0);
        step(1);
        check("irq_rise", {31'b0, irq}, 32'h1);
        wr(8'h00, 32'h2);
        check("irq_hold_after_clear", {31'b0, irq}, 32'h1);
        rd_chk(8'h00, 32'h0, "pr_cleared");
        step(1);
        check("irq_drop", {31'b0, irq}, 32'h0);
        BTNL = 1'b1;
        step(7);
        rd_chk(8'h00, 32'h1, "pl_set");
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("irq_masked_pl_%0d", i), {31'b0, irq}, 32'h0);
        end

        // Clear race: acceptance edge coincides with a W1C of PL
        BTNL = 1'b0;
        step(8);
        rd_chk(8'h00, 32'h1, "pl_still_pending");
        BTNL = 1'b1;
        step(6);
        rd_chk(8'h08, 32'h2, "race_db_l_not_yet");
        wr(8'h00, 32'h1);
        rd_chk(8'h00, 32'h1, "race_pl_kept");
        rd_chk(8'h08, 32'h3, "race_db_l_set");
        step(2);
        wr(8'h00, 32'h1);
        rd_chk(8'h00, 32'h0, "pl_cleared_later");

        // Short SW glitch must be rejected, steady change accepted
        SW = 16'h1235;
        step(3);
        SW = 16'h1234;
        step(10);
        rd_chk(8'h04, 32'h1234, "glitch_sw_kept");
        rd_chk(8'h00, 32'h0, "glitch_no_ps");
        SW = 16'hABCD;
        step(6);
        rd_chk(8'h04, 32'h1234, "sw_change_pending");
        step(1);
        rd_chk(8'h04, 32'hABCD, "sw_change_accepted");
        rd_chk(8'h00, 32'h4, "sw_change_ps");
        wr(8'h00, 32'h4);

        // Mid-debounce reset pulse at count 2
        BTNL = 1'b0;
        step(8);
        wr(8'h00, 32'h7);
        BTNL = 1'b1;
        step(5);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        rd_chk(8'h0C, 32'h0, "mid_rst_irq_en");
        rd_chk(8'h04, 32'h0, "mid_rst_switch");
        rd_chk(8'h08, 32'h0, "mid_rst_button");
        for (int i = 1; i <= 7; i++) begin
            step(1);
            addr = 8'h00;
            #1;
            check($sformatf("mid_rst_pl_e%0d", i), {31'b0, rdata[0]}, (i == 7) ? 32'd1 : 32'd0);
        end
        rd_chk(8'h00, 32'h7, "mid_rst_status");
        rd_chk(8'h08, 32'h3, "mid_rst_button_after");
        rd_chk(8'h04, 32'hABCD, "mid_rst_switch_after");
        step(2);
        check("mid_rst_irq_off", {31'b0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
